unidade_controle: RTL
=====================

// Module: unidade_controle
// PURPOSE
//   Control FSM of processador_multiciclo. Sequences each instruction through steps T0..T3 and decodes
//   IR = {opcode[8:6], Rx[5:3], Ry[2:0]} into register-enable, bus-driver and ALU controls.
//   The datapath holds the registers, A, G, the adder/subtractor and the BusWires mux.
// PARAMETERS
//   N_REGS  8  general registers R0..R7; width of Rin/Rout; Rx/Ry index fields are 3 bits
// PORTS
//   Clock   in   1       system clock, rising edge
//   Resetn  in   1       asynchronous reset, active low
//   Run     in   1       start request; sampled only in T0
//   IR      in   9       instruction register contents from datapath
//   IRin    out  1       load IR from DIN at end of this cycle
//   Rin     out  N_REGS  one-hot write enable for R0..R7
//   Rout    out  N_REGS  one-hot bus drive for R0..R7
//   DINout  out  1       DIN drives BusWires
//   Gout    out  1       G drives BusWires
//   Ain     out  1       load A from BusWires
//   Gin     out  1       load G with A +/- BusWires
//   AddSub  out  1       0 = add, 1 = subtract (valid when Gin=1)
//   Done    out  1       last step of current instruction
//   Tstep   out  2       current step (00=T0 .. 11=T3), registered
// BEHAVIOUR
// - State: only register is Tstep. All other outputs are combinational decode of (Tstep, IR, Run).
// - Reset: Resetn=0 forces Tstep=00 immediately, no clock required. While Resetn=0, every output is 0.
// - Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#DIN; 010 add Rx,Ry; 011 sub Rx,Ry.
//   100..111 are undefined and execute as NOP.
// - T0: IRin=Run. Run=1 -> T1; Run=0 -> stay in T0. No other output asserted.
// - T1, mv: Rout[Ry]=1, Rin[Rx]=1, Done=1 -> T0.
// - T1, mvi: DINout=1, Rin[Rx]=1, Done=1 -> T0.
// - T1, add/sub: Rout[Rx]=1, Ain=1 -> T2.
// - T1, NOP: Done=1 only, no enables -> T0.
// - T2, add/sub: Rout[Ry]=1, Gin=1, AddSub=(opcode==011) -> T3.
// - T3, add/sub: Gout=1, Rin[Rx]=1, Done=1 -> T0.
// - Latency from the Run edge in T0: mv/mvi/NOP complete in 2 cycles; add/sub in 4 cycles.
//   Done is high for exactly one cycle per instruction.
// - Run is ignored in T1..T3. If Run is still high when the FSM returns to T0, the next instruction
//   is fetched with no idle cycle.
// - IR must be stable during T1..T3. IR changes only on IRin, which is only asserted in T0.
// - Bus exclusivity: in every cycle at most one of {Rout[*], DINout, Gout} is 1. Rin and Rout are
//   each 0 or one-hot. No cycle drives the bus with nothing sampling it, except T1 of NOP.
// - Rx==Ry is legal. add R0,R0 yields 2*R0; mv R3,R3 is a no-op write.
// - Unreachable decode (Tstep=10/11 with a non-ALU opcode) drives all outputs 0 and returns to T0.
// - Reset mid-instruction: the instruction is abandoned, outputs drop to 0 asynchronously, and no
//   Rin/Gin fires. A and G may hold partial values. After Resetn rises, the FSM waits in T0 for Run.
// TESTING
// 1. mv R0,R1 (IR=000_000_001), Run pulse: T0 IRin=1; T1 Rout=00000010, Rin=00000001, Done=1;
//    then Tstep=00. With R1=10 preloaded, BusWires=10 in T1.
// 2. mvi R2 (IR=001_010_000), DIN=5: T1 DINout=1, Rin=00000100, Done=1; BusWires=5; next Tstep=00.
// 3. add R3,R4 (IR=010_011_100): T1 Rout=00001000, Ain=1; T2 Rout=00010000, Gin=1, AddSub=0;
//    T3 Gout=1, Rin=00001000, Done=1. With R3=7, R4=3 -> R3=10.
// 4. sub R3,R4 (IR=011_011_100): same sequence with AddSub=1 in T2. 7-3 -> R3=4.
//    Also sub R5,R5 -> R5=0.
// 5. Resetn=0 asynchronously in T2 of an add: Tstep=00 and all outputs 0 before the next edge;
//    Rin never asserted. After release with Run=0, the FSM stays in T0.
// 6. Run held high over mv, add, opcode 111: back-to-back fetches with IRin in each T0;
//    NOP gives Done in T1 and Rin=Rout=0. Throughout: one-hot bus-driver check and one Done per
//    instruction.

Source files
------------

// File: rtl/unidade_controle_if.sv
// Control bundle between the multicycle controller and its datapath.
// Latency: none, plain wires.
// Backpressure: none; Run is a level request sampled only while the controller sits in T0.
interface unidade_controle_if #(
  parameter int N_REGS = 8
);
  logic              Run;
  logic [8:0]        IR;
  logic              IRin;
  logic [N_REGS-1:0] Rin;
  logic [N_REGS-1:0] Rout;
  logic              DINout;
  logic              Gout;
  logic              Ain;
  logic              Gin;
  logic              AddSub;
  logic              Done;
  logic [1:0]        Tstep;

  // Controller side: consumes Run/IR, drives every control line.
  modport master (
    input  Run, IR,
    output IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Tstep
  );

  // Datapath side: supplies Run/IR, obeys the control lines.
  modport slave (
    output Run, IR,
    input  IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Tstep
  );
endinterface

// File: rtl/unidade_controle.sv
// Control FSM of the multicycle processor: steps T0..T3, decodes IR into bus/ALU/register enables.
// Latency: mv/mvi/NOP finish 2 cycles after the Run fetch, add/sub 4; Done pulses once per instruction.
// Backpressure: Run only matters in T0; held high it chains fetches back to back with no idle cycle.
module unidade_controle #(
  parameter int N_REGS = 8
) (
  input logic               Clock,
  input logic               Resetn,
  unidade_controle_if.master bus
);

  typedef enum logic [1:0] {T0 = 2'b00, T1 = 2'b01, T2 = 2'b10, T3 = 2'b11} tstep_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  tstep_e tstep_q, tstep_d;

  logic [2:0] opcode, rx, ry;
  logic       is_alu;

  logic              irin, dinout, gout, ain, gin, addsub, done;
  logic [N_REGS-1:0] rin, rout;

  assign opcode = bus.IR[8:6];
  assign rx     = bus.IR[5:3];
  assign ry     = bus.IR[2:0];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);

  function automatic logic [N_REGS-1:0] sel(input logic [2:0] idx);
    sel      = '0;
    sel[idx] = 1'b1;
  endfunction

  // Step register; reset abandons whatever instruction was in flight.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) tstep_q <= T0;
    else         tstep_q <= tstep_d;
  end

  // Next step and control decode from (step, opcode, Run).
  always_comb begin
    tstep_d = tstep_q;
    irin    = 1'b0;
    rin     = '0;
    rout    = '0;
    dinout  = 1'b0;
    gout    = 1'b0;
    ain     = 1'b0;
    gin     = 1'b0;
    addsub  = 1'b0;
    done    = 1'b0;
    unique case (tstep_q)
      T0: begin
        irin = bus.Run;
        if (bus.Run) tstep_d = T1;
      end
      T1: begin
        unique case (opcode)
          OP_MV: begin
            rout    = sel(ry);
            rin     = sel(rx);
            done    = 1'b1;
            tstep_d = T0;
          end
          OP_MVI: begin
            dinout  = 1'b1;
            rin     = sel(rx);
            done    = 1'b1;
            tstep_d = T0;
          end
          OP_ADD, OP_SUB: begin
            rout    = sel(rx);
            ain     = 1'b1;
            tstep_d = T2;
          end
          default: begin
            // Undefined opcodes retire as a NOP with no enables.
            done    = 1'b1;
            tstep_d = T0;
          end
        endcase
      end
      T2: begin
        if (is_alu) begin
          rout    = sel(ry);
          gin     = 1'b1;
          addsub  = (opcode == OP_SUB);
          tstep_d = T3;
        end else begin
          tstep_d = T0;
        end
      end
      T3: begin
        if (is_alu) begin
          gout = 1'b1;
          rin  = sel(rx);
          done = 1'b1;
        end
        tstep_d = T0;
      end
      default: tstep_d = T0;
    endcase
  end

  // Reset forces every control low immediately, without waiting for a clock.
  assign bus.IRin   = Resetn & irin;
  assign bus.Rin    = Resetn ? rin  : '0;
  assign bus.Rout   = Resetn ? rout : '0;
  assign bus.DINout = Resetn & dinout;
  assign bus.Gout   = Resetn & gout;
  assign bus.Ain    = Resetn & ain;
  assign bus.Gin    = Resetn & gin;
  assign bus.AddSub = Resetn & addsub;
  assign bus.Done   = Resetn & done;
  assign bus.Tstep  = tstep_q;

endmodule
